// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scan driver: per-slot dead-time, 16-level PWM dimming and
// frame-synchronous double-buffered digits. Optional feature macro: SEG_LEADING_ZERO_BLANK_EN.

module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_TICKS  = 2**17,
  parameter int unsigned BLANK_TICKS    = 64,
  parameter bit          ACTIVE_LOW_SEL = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_flat,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    update,
  input  logic [3:0]              brightness,
  output logic [3:0]              output_number,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_select,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_TICKS);
  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_TICKS - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(REFRESH_TICKS - 2);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{ACTIVE_LOW_SEL}};

  typedef enum logic {ST_BLANK, ST_PWM} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_slot_cnt;
  logic [SEL_W-1:0]        r_sel;
  logic [3:0]              r_pwm_cnt;
  logic [3:0]              r_bright_q;
  logic [4*NUM_DIGITS-1:0] r_shadow_dig, r_active_dig;
  logic [NUM_DIGITS-1:0]   r_shadow_dp, r_active_dp;

  logic                    w_slot_end, w_frame_end, w_lit;
  logic [NUM_DIGITS-1:0]   w_supp, w_onehot, w_sel_vec;
  logic [3:0]              w_cur_dig;

  assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_sel == SEL_LAST);
  assign w_cur_dig   = r_active_dig[{r_sel, 2'b00} +: 4];
  assign w_onehot    = NUM_DIGITS'(1) << r_sel;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_run;

  // Suppression run starts at the leftmost digit and ends at the first nonzero value or set dp.
  always_comb begin
    w_supp = '0;
    w_run  = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (w_run && (r_active_dig[4*i +: 4] == 4'd0) && !r_active_dp[i])
        w_supp[i] = 1'b1;
      else
        w_run = 1'b0;
    end
  end
`else
  assign w_supp = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_BLANK;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lit       = 1'b0;
    case (r_state)
      ST_BLANK: if (r_slot_cnt == BLANK_LAST) w_state_nxt = ST_PWM;
      ST_PWM: begin
        w_lit = (r_pwm_cnt <= r_bright_q) && !w_supp[r_sel];
        if (w_slot_end) w_state_nxt = ST_BLANK;
      end
      default: w_state_nxt = ST_BLANK;
    endcase
    w_sel_vec = w_lit ? (w_onehot ^ SEL_IDLE) : SEL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt    <= '0;
      r_sel         <= '0;
      r_pwm_cnt     <= '0;
      r_bright_q    <= '0;
      r_shadow_dig  <= '0;
      r_shadow_dp   <= '0;
      r_active_dig  <= '0;
      r_active_dp   <= '0;
      output_number <= '0;
      dp_out        <= 1'b0;
      digit_select  <= SEL_IDLE;
      frame_done    <= 1'b0;
    end else begin
      r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_end) r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
      r_pwm_cnt <= (r_state == ST_BLANK) ? 4'd0 : r_pwm_cnt + 4'd1;
      if (r_slot_cnt == '0) r_bright_q <= brightness;

      if (update) begin
        r_shadow_dig <= digits_flat;
        r_shadow_dp  <= dp_in;
      end
      if (w_frame_end) begin
        r_active_dig <= update ? digits_flat : r_shadow_dig;
        r_active_dp  <= update ? dp_in : r_shadow_dp;
      end

      output_number <= w_cur_dig;
      dp_out        <= r_active_dp[r_sel] && w_lit;
      digit_select  <= w_sel_vec;
      // Decoded one count early so the pulse coincides with the commit cycle.
      frame_done    <= (r_sel == SEL_LAST) && (r_slot_cnt == SLOT_PRE);
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: table of display vectors plus hand-written reset,
// brightness-timing and buffer-commit sequences; second instance covers active-high 8-digit.

module tb_seg_scan_mux;

  localparam int N = 4;
  localparam int R = 32;
  localparam int B = 4;
  localparam logic [3:0] IDLE = 4'b1111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_flat = '0;
  logic [3:0]  dp_in = '0;
  logic        update = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [3:0]  output_number;
  logic        dp_out;
  logic [3:0]  digit_select;
  logic        frame_done;

  logic [31:0] digits8 = 32'h87654321;
  logic [7:0]  dp8 = '0;
  logic        update8 = 1'b0;
  logic [3:0]  bright8 = 4'd15;
  logic [3:0]  num8;
  logic        dp_out8;
  logic [7:0]  dsel8;
  logic        fd8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_TICKS(R), .BLANK_TICKS(B), .ACTIVE_LOW_SEL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .digits_flat(digits_flat), .dp_in(dp_in), .update(update),
    .brightness(brightness), .output_number(output_number), .dp_out(dp_out),
    .digit_select(digit_select), .frame_done(frame_done));

  seg_scan_mux #(.NUM_DIGITS(8), .REFRESH_TICKS(20), .BLANK_TICKS(2), .ACTIVE_LOW_SEL(1'b0)) u_dut8 (
    .clk(clk), .reset(reset), .digits_flat(digits8), .dp_in(dp8), .update(update8),
    .brightness(bright8), .output_number(num8), .dp_out(dp_out8),
    .digit_select(dsel8), .frame_done(fd8));

  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic [3:0]      br;
    logic [3:0][5:0] lit;   // expected lit cycles per slot, index = digit
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!frame_done && n < 400);
    check(name, 32'(frame_done), 32'd1);
  endtask

  task automatic count_slot(input int chg_c, input logic [3:0] chg_b, output int lit);
    lit = 0;
    for (int c = 0; c < R; c++) begin
      tick;
      if (c == chg_c) brightness = chg_b;
      if (digit_select != IDLE) lit++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, sel_err, fd_err, lit, dpc, err;
    vec_t cur;
    logic [3:0] one, pat;
    logic [7:0] one8;

    tbl[0] = '{dig:16'h4321, dp:4'b0000, br:4'd15, lit:{6'd28, 6'd28, 6'd28, 6'd28}};
    tbl[1] = '{dig:16'h9999, dp:4'b0101, br:4'd7,  lit:{6'd16, 6'd16, 6'd16, 6'd16}};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    tbl[2] = '{dig:16'h0050, dp:4'b0000, br:4'd0,  lit:{6'd0,  6'd0,  6'd2,  6'd2}};
`else
    tbl[2] = '{dig:16'h0050, dp:4'b0000, br:4'd0,  lit:{6'd2,  6'd2,  6'd2,  6'd2}};
`endif
    tbl[3] = '{dig:16'h0050, dp:4'b1000, br:4'd15, lit:{6'd28, 6'd28, 6'd28, 6'd28}};
    tbl[4] = '{dig:16'hF0E1, dp:4'b0010, br:4'd3,  lit:{6'd8,  6'd8,  6'd8,  6'd8}};

    // Reset values and start-up timing
    repeat (3) tick;
    check("rst_sel", 32'(digit_select), 32'hF);
    check("rst_num", 32'(output_number), 32'd0);
    check("rst_dp", 32'(dp_out), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_sel8", 32'(dsel8), 32'd0);
    reset = 1'b0;
    n = 0;
    first = -1;
    do begin
      tick;
      n++;
      if (first < 0 && digit_select != IDLE) begin
        first = n;
        check("first_pat", 32'(digit_select), 32'hE);
      end
    end while (!frame_done && n < 300);
    check("first_lit", 32'(first), 32'd5);
    check("first_fd", 32'(n), 32'd127);

    // Table-driven display frames
    for (int v = 0; v < 5; v++) begin
      cur = tbl[v];
      wait_fd($sformatf("v%0d_fd_a", v));
      repeat (40) tick;
      digits_flat = cur.dig;
      dp_in = cur.dp;
      brightness = cur.br;
      update = 1'b1;
      tick;
      update = 1'b0;
      wait_fd($sformatf("v%0d_fd_b", v));
      tick;
      sel_err = 0;
      fd_err = 0;
      for (int s = 0; s < N; s++) begin
        one = 4'b0001 << s;
        pat = ~one;
        lit = 0;
        dpc = 0;
        for (int c = 0; c < R; c++) begin
          tick;
          if (digit_select == pat) lit++;
          else if (digit_select != IDLE) sel_err++;
          if (c < B && digit_select != IDLE) sel_err++;
          if (dp_out) dpc++;
          if (frame_done !== ((s == N - 1) && (c == R - 2))) fd_err++;
          if (c == R / 2)
            check($sformatf("v%0d_num%0d", v, s), 32'(output_number), 32'(cur.dig[4*s +: 4]));
        end
        check($sformatf("v%0d_lit%0d", v, s), 32'(lit), 32'(cur.lit[s]));
        check($sformatf("v%0d_dp%0d", v, s), 32'(dpc), cur.dp[s] ? 32'(cur.lit[s]) : 32'd0);
      end
      check($sformatf("v%0d_selerr", v), 32'(sel_err), 32'd0);
      check($sformatf("v%0d_fderr", v), 32'(fd_err), 32'd0);
    end

    // Brightness change mid-slot applies from the next slot only
    brightness = 4'd15;
    wait_fd("br_fd");
    tick;
    count_slot(10, 4'd0, lit);
    check("br_slot0", 32'(lit), 32'd28);
    count_slot(-1, 4'd0, lit);
    check("br_slot1", 32'(lit), 32'd2);
    brightness = 4'd15;

    // Mid-frame update held in shadow until the frame boundary
    wait_fd("hold_fd0");
    repeat (40) tick;
    digits_flat = 16'h9999;
    dp_in = 4'b0000;
    update = 1'b1;
    tick;
    update = 1'b0;
    n = 0;
    err = 0;
    do begin
      tick;
      n++;
      if (output_number == 4'd9) err++;
    end while (!frame_done && n < 300);
    check("hold_early", 32'(err), 32'd0);
    check("hold_fd", 32'(frame_done), 32'd1);
    tick;
    check("hold_old", 32'(output_number), 32'hF);
    tick;
    check("hold_new", 32'(output_number), 32'd9);

    // Update on the boundary cycle bypasses the shadow and also loads it
    wait_fd("bnd_fd");
    digits_flat = 16'h8765;
    update = 1'b1;
    tick;
    update = 1'b0;
    check("bnd_old", 32'(output_number), 32'd9);
    tick;
    check("bnd_d0", 32'(output_number), 32'd5);
    repeat (R) tick;
    check("bnd_d1", 32'(output_number), 32'd6);
    wait_fd("bnd_fd2");
    repeat (2) tick;
    check("bnd_keep", 32'(output_number), 32'd5);

    // Reset while digit 2 is lit
    n = 0;
    while (digit_select != 4'b1011 && n < 300) begin
      tick;
      n++;
    end
    check("mid_find", 32'(digit_select), 32'hB);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    check("mid_sel", 32'(digit_select), 32'hF);
    check("mid_num", 32'(output_number), 32'd0);
    check("mid_fd", 32'(frame_done), 32'd0);
    check("mid_dp", 32'(dp_out), 32'd0);
    check("mid_sel8", 32'(dsel8), 32'd0);
    reset = 1'b0;
    err = 0;
    for (int k = 1; k <= 170; k++) begin
      tick;
      if (k < 5 && digit_select != IDLE) err++;
      if (k == 5) begin
        check("rs_sel", 32'(digit_select), 32'hE);
        check("rs_num", 32'(output_number), 32'd0);
      end
      if (k >= 10 && (k - 10) % 20 == 0 && (k - 10) / 20 < 8) begin
        one8 = 8'd1 << ((k - 10) / 20);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if ((k - 10) / 20 != 0) one8 = '0;
`endif
        check($sformatf("sel8_%0d", (k - 10) / 20), 32'(dsel8), 32'(one8));
      end
    end
    check("rs_blank", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised time-multiplexed driver for common-anode/cathode seven-segment banks, the generalised successor to the fixed 4-digit BCD scan mux. Scans NUM_DIGITS nibble-coded digits with per-digit decimal points, inserts a programmable dead-time between digit slots to suppress ghosting, and applies 16-level PWM brightness within each slot. Input digits are double-buffered and committed only at frame boundaries, so the displayed value never tears. Sits between the calculator datapath and the segment decoder/pin drivers.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal 2..8
- REFRESH_TICKS, 2**17, clk cycles per digit slot; must exceed BLANK_TICKS+16
- BLANK_TICKS, 64, dead-time cycles at the start of each slot, all digits off; legal 1..REFRESH_TICKS-17
- ACTIVE_LOW_SEL, 1, 1: a selected digit drives 0; 0: a selected digit drives 1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- digits_flat  in  4*NUM_DIGITS  digit i value at bits [4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- update  in  1  strobe; captures digits_flat/dp_in into the shadow buffer
- brightness  in  4  PWM level; lit fraction (brightness+1)/16
- output_number  out  4  value of the currently scanned digit
- dp_out  out  1  decimal point of the currently scanned digit, lit-qualified
- digit_select  out  NUM_DIGITS  one-hot (polarity per ACTIVE_LOW_SEL) digit enable
- frame_done  out  1  one-cycle pulse on the last cycle of slot NUM_DIGITS-1

## Operation
- Slot counter slot_cnt counts 0..REFRESH_TICKS-1, then wraps to 0; on wrap, digit index sel advances, wrapping NUM_DIGITS-1 -> 0.
- Per-slot state machine: BLANK (slot_cnt < BLANK_TICKS) -> ON/OFF (remainder of slot) -> BLANK at the next slot.
- BLANK: digit_select all inactive, dp_out 0; output_number already shows the new sel digit (settling time for decoder).
- ON/OFF: 4-bit pwm_cnt clears on entry to ON/OFF and increments every cycle, wrapping at 15. Digit sel is driven active when pwm_cnt <= bright_q, otherwise inactive (OFF).
- bright_q samples brightness on the first cycle of each slot and is held for that slot.
- Buffers: shadow loads on update. At the frame boundary (cycle frame_done=1), active <= shadow. If update coincides with the boundary, active loads digits_flat/dp_in directly and shadow also loads them.
- output_number = active digit[sel]; dp_out = active dp[sel] AND digit currently lit.
- All outputs registered.

## Timing
- Reset values: output_number 0, dp_out 0, frame_done 0, digit_select all inactive (all 1 if ACTIVE_LOW_SEL=1, else all 0); sel 0, slot_cnt 0, pwm_cnt 0, bright_q 0, shadow and active 0.
- Outputs lag internal counters by one register stage: first active digit_select is BLANK_TICKS+1 cycles after reset deassert.
- Update-to-display latency: from the next frame boundary up to one full frame (NUM_DIGITS*REFRESH_TICKS cycles), plus BLANK_TICKS+1.
- Frame period exactly NUM_DIGITS*REFRESH_TICKS cycles; frame_done period identical.
- Reset mid-slot: next cycle all outputs at reset values; scan restarts at digit 0 BLANK.
- Never more than one digit_select bit active; all inactive in BLANK.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: active digits from index NUM_DIGITS-1 downward with value 0 and dp 0 are suppressed (digit_select stays inactive for their whole slot; slot timing unchanged). Suppression stops at the first nonzero digit or a set dp. Digit 0 is never suppressed.
- Undefined: every digit is lit per PWM regardless of value.

## Test plan
- NUM_DIGITS=4, REFRESH_TICKS=32, BLANK_TICKS=4, brightness=15, update digits 4,3,2,1 (digit3..0) -> after frame boundary, digit_select 1110/1101/1011/0111 each lit 28 cycles after a 4-cycle all-1 gap; output_number 1,2,3,4; frame_done every 128 cycles.
- brightness=0 -> each slot lit 1 cycle in 16 of ON/OFF; brightness=7 -> 8 of 16; change brightness mid-slot -> takes effect next slot only.
- Update with digits 9,9,9,9 mid-frame -> display unchanged until frame_done cycle, then 9s; update on the exact frame_done cycle -> new value shown from the very next slot 0.
- Assert reset mid-ON of digit 2 -> next cycle digit_select=1111, output_number=0, frame_done=0; scan resumes at digit 0.
- SEG_LEADING_ZERO_BLANK_EN, digits 0,0,5,0 -> digits 3,2 never selected, digits 1,0 shown; with dp_in[3]=1 -> digit 3 shown, digit 2 suppressed only if its own dp=0 and it precedes a zero run (here shown, since blanking stops at digit 3).
- ACTIVE_LOW_SEL=0, NUM_DIGITS=8 -> one-hot active-high select cycling 00000001..10000000, reset value 00000000.
